debnc_scan: RTL

//  Multi-channel debounce controller for front-panel buttons/switches: one shared sample-tick prescaler

---
 rtl/debnc_scan.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/debnc_scan.sv
// Multi-channel debouncer: one shared sample-tick prescaler drives per-channel stability integrators.
// Define DEBNC_SCAN_EVENTS_EN to build the round-robin edge-event queue (valid/ready) and overrun flag.

module debnc_scan_chan #(
    parameter int Stable = 4,
    parameter int CW     = 3
) (
    input  logic clock,
    input  logic reset,
    input  logic tick_i,
    input  logic s_i,
    output logic level_o,
    output logic change_o
);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;

    always_comb begin
        cnt_d    = cnt_q;
        level_d  = level_q;
        change_o = 1'b0;
        if (tick_i) begin
            if (s_i == level_q) begin
                cnt_d = '0;
            end else if (cnt_q == CW'(Stable - 1)) begin
                level_d  = ~level_q;
                cnt_d    = '0;
                change_o = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    assign level_o = level_q;
endmodule

module debnc_scan #(
    parameter int Channels = 8,
    parameter int TickDiv  = 64,
    parameter int Stable   = 4,
    parameter int Inverted = 0,
    localparam int CHW     = (Channels > 1) ? $clog2(Channels) : 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [Channels-1:0] sigin,
    output logic [Channels-1:0] sigout,
    output logic                evt_valid,
    input  logic                evt_ready,
    output logic [CHW-1:0]      evt_chan,
    output logic                evt_rise,
    output logic                overrun
);
    localparam int PW = $clog2(TickDiv);
    localparam int CW = $clog2(Stable + 1);

    logic [Channels-1:0] sync1_q, sync2_q, s, change;
    logic [PW-1:0]       presc_q;
    logic                tick;

    assign tick = (presc_q == PW'(TickDiv - 1));
    assign s    = (Inverted != 0) ? ~sync2_q : sync2_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            presc_q <= '0;
        end else begin
            sync1_q <= sigin;
            sync2_q <= sync1_q;
            presc_q <= tick ? '0 : presc_q + PW'(1);
        end
    end

    for (genvar i = 0; i < Channels; i++) begin : g_chan
        debnc_scan_chan #(.Stable(Stable), .CW(CW)) u_chan (
            .clock    (clock),
            .reset    (reset),
            .tick_i   (tick),
            .s_i      (s[i]),
            .level_o  (sigout[i]),
            .change_o (change[i])
        );
    end

`ifdef DEBNC_SCAN_EVENTS_EN
    typedef enum logic {IDLE, PRESENT} state_t;

    state_t              state_q, state_d;
    logic [Channels-1:0] pend_q, pend_d, dir_q, dir_d, clr;
    logic [CHW-1:0]      rr_q, rr_d, chan_q, chan_d, pick, cand;
    logic                rise_q, rise_d, ovr_q, ovr_d, found, accept;

    // First pending channel at or after the round-robin pointer, wrapping.
    always_comb begin
        int idx;
        idx   = 0;
        cand  = '0;
        pick  = rr_q;
        found = 1'b0;
        for (int k = 0; k < Channels; k++) begin
            idx = int'(rr_q) + k;
            if (idx >= Channels) idx = idx - Channels;
            cand = CHW'(idx);
            if (!found && pend_q[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    // A change landing on the channel being accepted keeps it pending, so it is re-presented.
    always_comb begin
        accept  = (state_q == PRESENT) && evt_ready;
        clr     = '0;
        if (accept) clr[chan_q] = 1'b1;
        pend_d  = (pend_q & ~clr) | change;
        dir_d   = (dir_q & ~change) | (change & ~sigout);
        ovr_d   = |(change & pend_q & ~clr);
        state_d = state_q;
        chan_d  = chan_q;
        rise_d  = rise_q;
        rr_d    = rr_q;
        case (state_q)
            IDLE: if (found) begin
                chan_d  = pick;
                rise_d  = dir_q[pick];
                state_d = PRESENT;
            end
            PRESENT: if (evt_ready) begin
                state_d = IDLE;
                rr_d    = (chan_q == CHW'(Channels - 1)) ? '0 : chan_q + CHW'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            pend_q  <= '0;
            dir_q   <= '0;
            rr_q    <= '0;
            chan_q  <= '0;
            rise_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            dir_q   <= dir_d;
            rr_q    <= rr_d;
            chan_q  <= chan_d;
            rise_q  <= rise_d;
            ovr_q   <= ovr_d;
        end
    end

    assign evt_valid = (state_q == PRESENT);
    assign evt_chan  = chan_q;
    assign evt_rise  = rise_q;
    assign overrun   = ovr_q;
`else
    logic unused_evt;
    assign unused_evt = ^{evt_ready, change};
    assign evt_valid  = 1'b0;
    assign evt_chan   = '0;
    assign evt_rise   = 1'b0;
    assign overrun    = 1'b0;
`endif
endmodule
